// File: rtl/seq_mag_comp_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
// Result encoding is {lt, eq, gt}.
package seq_mag_comp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] RES_LT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_GT   = 3'b001;
    localparam logic [2:0] RES_NONE = 3'b000;

    // Encode a single-bit comparison into the {lt, eq, gt} form.
    function automatic logic [2:0] encode_res(input logic is_lt, input logic is_gt);
        if (is_gt) begin
            return RES_GT;
        end else if (is_lt) begin
            return RES_LT;
        end
        return RES_EQ;
    endfunction

endpackage

// File: rtl/seq_mag_comp_bit_comp_cell.sv
// Combinational one-bit magnitude compare cell.
module bit_comp_cell (
    input  logic a_bit,
    input  logic b_bit,
    output logic lt,
    output logic eq,
    output logic gt
);

    assign lt = ~a_bit & b_bit;
    assign gt = a_bit & ~b_bit;
    assign eq = ~(a_bit ^ b_bit);

endmodule

// File: rtl/seq_mag_comp.sv
// Bit-serial MSB-first magnitude comparator (IDLE -> RUN -> DONE).
// Optional SEQ_MAG_COMP_EARLY_EXIT_EN ends RUN at the first differing bit.
module seq_mag_comp
    import seq_mag_comp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam int CW = $clog2(WIDTH + 1);

    // Handshake: start is accepted only in IDLE with en=1; busy is high while
    // the comparison runs; done pulses for one cycle with lt/eq/gt valid, and
    // those outputs hold until the next accepted start.
    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CW-1:0]    cnt;
    logic             diff_found;
    logic [2:0]       diff_res;
    logic [2:0]       res;

    logic cell_lt;
    logic cell_eq;
    logic cell_gt;

    bit_comp_cell u_cell (
        .a_bit (sh_a[WIDTH-1]),
        .b_bit (sh_b[WIDTH-1]),
        .lt    (cell_lt),
        .eq    (cell_eq),
        .gt    (cell_gt)
    );

    logic       accept;
    logic       step;
    logic       last_bit;
    logic       finish;
    logic [2:0] cell_res;
    logic [2:0] final_res;

    assign accept   = (state == IDLE) && en && start;
    assign step     = (state == RUN) && en;
    assign last_bit = step && (cnt <= CW'(1));
    assign cell_res = encode_res(cell_lt, cell_gt);
    // The bit seen on the finishing edge counts if nothing was latched earlier.
    assign final_res = diff_found ? diff_res : cell_res;

`ifdef SEQ_MAG_COMP_EARLY_EXIT_EN
    assign finish = last_bit || (step && !cell_eq);
`else
    assign finish = last_bit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (finish) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a       <= '0;
            sh_b       <= '0;
            cnt        <= '0;
            diff_found <= 1'b0;
            diff_res   <= RES_NONE;
            res        <= RES_NONE;
        end else if (accept) begin
            sh_a       <= a;
            sh_b       <= b;
            cnt        <= CW'(WIDTH);
            diff_found <= 1'b0;
            diff_res   <= RES_NONE;
            res        <= RES_NONE;
        end else if (step) begin
            sh_a <= {sh_a[WIDTH-2:0], 1'b0};
            sh_b <= {sh_b[WIDTH-2:0], 1'b0};
            if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (!diff_found && !cell_eq) begin
                diff_found <= 1'b1;
                diff_res   <= cell_res;
            end
            if (finish) begin
                res <= final_res;
            end
        end
    end

    assign busy         = (state == RUN);
    assign done         = (state == DONE);
    assign {lt, eq, gt} = res;

endmodule

// File: tb/tb_seq_mag_comp.sv
// Self-checking bench for seq_mag_comp (WIDTH=8): directed cases plus
// randomized operands and enable stalls against an arithmetic reference.
module tb_seq_mag_comp;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         lt;
    logic         eq;
    logic         gt;

    int n_checks = 0;
    int n_errors = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    seq_mag_comp #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .lt    (lt),
        .eq    (eq),
        .gt    (gt)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Enabled bit-cycles needed before done.
    function automatic int exp_bits(input logic [W-1:0] ta, input logic [W-1:0] tb);
`ifdef SEQ_MAG_COMP_EARLY_EXIT_EN
        for (int p = 0; p < W; p++) begin
            if (ta[W-1-p] != tb[W-1-p]) return p + 1;
        end
`endif
        return W;
    endfunction

    task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input int stall_at, input int stall_len, input bit poke);
        int         need;
        int         t;
        int         e;
        int         edges;
        int         busy_cycles;
        int         extra_done;
        bit         seen;
        logic [2:0] exp_res;
        logic [2:0] held;

        exp_res = (ta < tb) ? 3'b100 : ((ta == tb) ? 3'b010 : 3'b001);
        exp_q.push_back(exp_res);

        need = exp_bits(ta, tb);
        t = 0;
        e = 0;
        while (e < need) begin
            if (!(t >= stall_at && t < stall_at + stall_len)) e++;
            t++;
        end

        @(negedge clk);
        a = ta; b = tb; start = 1'b1; en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);

        edges = 0;
        busy_cycles = 0;
        seen = 1'b0;
        while (edges < 64) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            en = !(edges >= stall_at && edges < stall_at + stall_len);
            start = poke && (edges == 3);
            @(posedge clk);
            edges++;
            @(negedge clk);
            start = 1'b0;
        end
        en = 1'b1;

        check_val("done_seen", 64'(seen), 64'd1);
        check_val("latency", 64'(edges), 64'(t));
        check_val("busy_cycles", 64'(busy_cycles), 64'(t));
        check_val("result", {61'd0, lt, eq, gt}, {61'd0, exp_q.pop_front()});
        check_val("onehot", 64'($countones({lt, eq, gt})), 64'd1);
        held = {lt, eq, gt};

        @(posedge clk);
        @(negedge clk);
        check_val("done_pulse", {62'd0, done, busy}, 64'd0);
        check_val("result_hold", {61'd0, lt, eq, gt}, {61'd0, held});

        if (poke) begin
            extra_done = 0;
            for (int i = 0; i < 12; i++) begin
                @(posedge clk);
                @(negedge clk);
                if (done || busy) extra_done++;
            end
            check_val("no_second_done", 64'(extra_done), 64'd0);
        end
    endtask

    initial begin
        int         stray;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst = 1'b1; en = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset_outputs", {59'd0, busy, done, lt, eq, gt}, 64'd0);
        rst = 1'b0;
        en  = 1'b1;

        run_txn(8'h00, 8'h00, 99, 0, 1'b0);
        run_txn(8'h80, 8'h7F, 99, 0, 1'b0);
        run_txn(8'h12, 8'h13, 99, 0, 1'b1);
        run_txn(8'h55, 8'h54, 2, 3, 1'b0);
        run_txn(8'hFF, 8'hFF, 99, 0, 1'b0);
        run_txn(8'h00, 8'hFF, 99, 0, 1'b0);
        run_txn(8'h01, 8'h00, 99, 0, 1'b0);
        run_txn(8'hFE, 8'hFF, 1, 2, 1'b0);

        // Reset sampled at E0+4 aborts the run with no done pulse.
        @(negedge clk);
        a = 8'h3C; b = 8'h3C; start = 1'b1; en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_val("busy_before_rst", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("abort_outputs", {59'd0, busy, done, lt, eq, gt}, 64'd0);
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) stray++;
        end
        check_val("abort_no_done", 64'(stray), 64'd0);

        // start with en=0 in IDLE must not be accepted.
        en = 1'b0; start = 1'b1; a = 8'h01; b = 8'h02;
        stray = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy || done) stray++;
        end
        start = 1'b0;
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("en0_no_accept", {61'd0, 1'(stray != 0), busy, done}, 64'd0);

        for (int n = 0; n < 30; n++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = ra;
                1:       rb = ra ^ W'(1 << $urandom_range(0, W - 1));
                default: rb = W'($urandom);
            endcase
            run_txn(ra, rb, $urandom_range(0, 10), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_mag_comp.md
SEQ_MAG_COMP -- requirements
Module: seq_mag_comp

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..64.
REQ-002 clk  input  1  sole clock, rising-edge active.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 en  input  1  global enable; 0 freezes all state.
REQ-005 start  input  1  request to compare a and b.
REQ-006 a  input  WIDTH  unsigned operand A.
REQ-007 b  input  WIDTH  unsigned operand B.
REQ-008 busy  output  1  comparison in progress.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 lt  output  1  A < B.
REQ-011 eq  output  1  A == B.
REQ-012 gt  output  1  A > B.

Function
REQ-013 The block SHALL be a bit-serial, MSB-first magnitude comparator with FSM states IDLE, RUN and DONE.
REQ-014 In IDLE, start=1 with en=1 SHALL capture a and b into shift registers, load the bit counter with WIDTH, clear lt/eq/gt to 000, and enter RUN at that edge (acceptance edge, E0).
REQ-015 start SHALL be ignored in RUN and DONE, and whenever en=0.
REQ-016 busy SHALL be 1 exactly while the state is RUN.
REQ-017 In RUN, each edge with en=1 SHALL compare the current MSBs of both shift registers, shift both left by one, and decrement the counter.
REQ-018 The first differing bit SHALL latch the verdict (A bit 1 -> gt, B bit 1 -> lt); later bits SHALL NOT change a latched verdict.
REQ-019 With en=0 in RUN, registers, counter and state SHALL hold.
REQ-020 When the counter reaches 0, the FSM SHALL enter DONE; at that edge lt/eq/gt SHALL be updated (eq=1 if no difference was latched) and done SHALL be 1.
REQ-021 Without stalls, done SHALL be high in the cycle after edge E0+WIDTH.
REQ-022 DONE SHALL return to IDLE on the next edge regardless of en; done SHALL therefore be a single-cycle pulse.
REQ-023 lt/eq/gt SHALL hold their values from done until the next accepted start; when done=1 exactly one of them SHALL be 1.
REQ-024 The counter width SHALL be $clog2(WIDTH+1) bits, with no wrap below 0.

Reset
REQ-025 rst=1 SHALL force IDLE, and busy=done=lt=eq=gt=0, clearing the shift registers and counter at the next edge.
REQ-026 rst SHALL take priority over en and start, and SHALL abort a RUN in progress without a done pulse.

Configuration
REQ-027 Macro SEQ_MAG_COMP_EARLY_EXIT_EN: when defined, RUN SHALL exit to DONE on the edge that latches the first differing bit; for a first difference at MSB-relative position p (0=MSB), done SHALL be high after edge E0+p+1.
REQ-028 Without SEQ_MAG_COMP_EARLY_EXIT_EN, latency SHALL always be WIDTH bit-cycles, regardless of operand values.
REQ-029 The result values SHALL be identical in both builds.

Structure
REQ-030 The package seq_mag_comp_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the 3-bit result encoding constants (LT=100, EQ=010, GT=001).
REQ-031 The per-bit compare SHALL be the combinational sub-module bit_comp_cell (inputs: one A bit and one B bit; outputs lt, eq, gt), instantiated once.

Verification (WIDTH=8)
REQ-032 a=0x00, b=0x00, start -> busy for 8 cycles, done at E0+8, eq=1, lt=gt=0.
REQ-033 a=0x80, b=0x7F -> gt=1; done at E0+1 with EARLY_EXIT_EN, E0+8 without.
REQ-034 a=0x12, b=0x13 -> lt=1, done at E0+8 in both builds; a start pulse during RUN is ignored and yields no second done.
REQ-035 a=0x55, b=0x54, en=0 for 3 cycles mid-RUN -> done delayed to E0+11, gt=1.
REQ-036 rst at E0+4 -> next cycle all outputs 0, no done; start with en=0 in IDLE -> no acceptance, busy stays 0.
